// File: rtl/coin_payer.sv
// Customer-side coin issuer: pays a requested amount in 2/1-yuan pulses,
// stops on the vendor's first vend and reports change, remainder and timeout.
module coin_payer #(
   parameter int AMT_W   = 4,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic             busy,
   output logic [1:0]       coin,
   input  logic             vend_vld,
   input  logic [1:0]       vend_chg,
   output logic             done,
   output logic [1:0]       done_chg,
   output logic [AMT_W-1:0] done_left,
   output logic             err
);
   localparam int GW = $clog2(GAP + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, COIN, GAP_S, WAIT, DONE} state_t;

   state_t           state, nstate;
   logic [AMT_W-1:0] rem, rem_d;
   logic [GW-1:0]    gap_cnt, gap_d;
   logic [TW-1:0]    to_cnt, to_d;
   logic             vended, vended_d;
   logic [1:0]       chg_cap, chg_cap_d;
   logic [1:0]       coin_d, done_chg_d;
   logic [AMT_W-1:0] done_left_d;
   logic             busy_d, done_d, err_d;
   logic             accept, active, timeout;

   assign accept  = (state == IDLE) && start && (amt != '0);
   assign active  = (state == COIN) || (state == GAP_S) || (state == WAIT);
   assign timeout = (state == WAIT) && !vend_vld && (to_cnt == TW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rem       <= '0;
         gap_cnt   <= '0;
         to_cnt    <= '0;
         vended    <= 1'b0;
         chg_cap   <= 2'd0;
         coin      <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_chg  <= 2'd0;
         done_left <= '0;
         err       <= 1'b0;
      end else begin
         state     <= nstate;
         rem       <= rem_d;
         gap_cnt   <= gap_d;
         to_cnt    <= to_d;
         vended    <= vended_d;
         chg_cap   <= chg_cap_d;
         coin      <= coin_d;
         busy      <= busy_d;
         done      <= done_d;
         done_chg  <= done_chg_d;
         done_left <= done_left_d;
         err       <= err_d;
      end
   end

   // A vend arriving in the final gap cycle itself still ends the payment.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:  if (accept) nstate = COIN;
         COIN:  nstate = GAP_S;
         GAP_S: if (gap_cnt == GW'(1)) begin
                   if (vended || vend_vld) nstate = DONE;
                   else if (rem != '0)     nstate = COIN;
                   else                    nstate = WAIT;
                end
         WAIT:  if (vend_vld || timeout) nstate = DONE;
         DONE:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      rem_d       = rem;
      gap_d       = gap_cnt;
      to_d        = to_cnt;
      vended_d    = vended;
      chg_cap_d   = chg_cap;
      done_chg_d  = done_chg;
      done_left_d = done_left;
      err_d       = err;

      if (accept)             rem_d = amt;
      else if (state == COIN) rem_d = rem - AMT_W'(coin);

      if (state == COIN)       gap_d = GW'(GAP);
      else if (state == GAP_S) gap_d = gap_cnt - GW'(1);

      if (state == GAP_S && nstate == WAIT) to_d = TW'(TIMEOUT);
      else if (state == WAIT)               to_d = to_cnt - TW'(1);

      if (accept) begin
         vended_d   = 1'b0;
         chg_cap_d  = 2'd0;
         done_chg_d = 2'd0;
         done_left_d = '0;
         err_d      = 1'b0;
      end else if (active && vend_vld && !vended) begin
         vended_d  = 1'b1;
         chg_cap_d = vend_chg;
      end

      if (nstate == DONE) begin
         done_chg_d  = timeout ? 2'd0 : chg_cap_d;
         done_left_d = timeout ? '0 : rem_d;
         err_d       = timeout;
      end

      coin_d = 2'd0;
      if (nstate == COIN) coin_d = (rem_d >= AMT_W'(2)) ? 2'd2 : 2'd1;
      busy_d = (nstate != IDLE);
      done_d = (nstate == DONE);
   end
endmodule

// File: tb/tb_coin_payer.sv
// Directed bench for coin_payer (GAP=1, TIMEOUT=16) with hand-computed cycle expectations.
module tb_coin_payer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] amt = 4'd0;
   logic       busy;
   logic [1:0] coin;
   logic       vend_vld = 1'b0;
   logic [1:0] vend_chg = 2'd0;
   logic       done;
   logic [1:0] done_chg;
   logic [3:0] done_left;
   logic       err;
   int         n_chk = 0;
   int         n_err = 0;

   coin_payer #(.AMT_W(4), .GAP(1), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .amt(amt), .busy(busy),
      .coin(coin), .vend_vld(vend_vld), .vend_chg(vend_chg), .done(done),
      .done_chg(done_chg), .done_left(done_left), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [3:0] a);
      start = 1'b1; amt = a;
      tick();
      start = 1'b0; amt = 4'd0;
   endtask

   initial begin
      #12 rst_n = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_coin", coin, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_left", done_left, 0);

      // amt=4: coins 2,2, vend with the second coin
      pulse_start(4'd4);                       // t+1
      chk("a4_busy", busy, 1);
      chk("a4_c1", coin, 2);
      tick();                                  // t+2
      chk("a4_gap", coin, 0);
      tick();                                  // t+3
      chk("a4_c2", coin, 2);
      vend_vld = 1'b1; vend_chg = 2'd0;
      tick();                                  // t+4
      vend_vld = 1'b0;
      chk("a4_gap2_coin", coin, 0);
      chk("a4_gap2_done", done, 0);
      tick();                                  // t+5
      chk("a4_done", done, 1);
      chk("a4_chg", done_chg, 0);
      chk("a4_left", done_left, 0);
      chk("a4_err", err, 0);
      tick();                                  // t+6
      chk("a4_idle_busy", busy, 0);
      chk("a4_idle_done", done, 0);

      // amt=5: vend in second gap stops the third coin
      pulse_start(4'd5);
      chk("a5_c1", coin, 2);
      tick(); tick();
      chk("a5_c2", coin, 2);
      tick();                                  // t+4 gap
      vend_vld = 1'b1; vend_chg = 2'd0;
      tick();                                  // t+5
      vend_vld = 1'b0;
      chk("a5_no_c3", coin, 0);
      chk("a5_done", done, 1);
      chk("a5_left", done_left, 1);
      chk("a5_chg", done_chg, 0);
      tick();

      // amt=2: vend with chg=1 on the coin cycle; later pulse ignored
      pulse_start(4'd2);
      chk("a2_c1", coin, 2);
      vend_vld = 1'b1; vend_chg = 2'd1;
      tick();                                  // t+2 gap
      vend_chg = 2'd2;                         // second pulse must be ignored
      chk("a2_gap", coin, 0);
      tick();                                  // t+3
      vend_vld = 1'b0; vend_chg = 2'd0;
      chk("a2_done", done, 1);
      chk("a2_chg", done_chg, 1);
      chk("a2_left", done_left, 0);
      tick();
      chk("a2_hold_chg", done_chg, 1);

      // amt=3: coins 2,1, no vend -> timeout after 16 WAIT cycles
      pulse_start(4'd3);
      chk("a3_c1", coin, 2);
      tick(); tick();                          // t+3
      chk("a3_c2", coin, 1);
      tick(); tick();                          // t+5 first WAIT cycle
      chk("a3_wait_busy", busy, 1);
      for (int i = 0; i < 15; i++) tick();     // t+20 last WAIT cycle
      chk("a3_not_yet", done, 0);
      chk("a3_wait_coin", coin, 0);
      tick();                                  // t+21
      chk("a3_done", done, 1);
      chk("a3_err", err, 1);
      chk("a3_left", done_left, 0);
      chk("a3_chg", done_chg, 0);
      tick();
      chk("a3_hold_err", err, 1);

      // amt=0 ignored
      pulse_start(4'd0);
      chk("a0_busy", busy, 0);
      chk("a0_err_held", err, 1);

      // start during busy ignored, then back-to-back start accepted
      pulse_start(4'd4);                       // t+1
      chk("bb_c1", coin, 2);
      chk("bb_err_clr", err, 0);
      tick();                                  // t+2
      start = 1'b1; amt = 4'd1;
      tick();                                  // t+3
      start = 1'b0; amt = 4'd0;
      chk("bb_c2_unchanged", coin, 2);
      vend_vld = 1'b1; vend_chg = 2'd0;
      tick();                                  // t+4
      vend_vld = 1'b0;
      tick();                                  // t+5
      chk("bb_done", done, 1);
      tick();                                  // t+6 first IDLE
      chk("bb_idle", busy, 0);
      pulse_start(4'd1);                       // t+7
      chk("bb2_busy", busy, 1);
      chk("bb2_c1", coin, 1);
      tick(); tick();                          // t+9 WAIT
      vend_vld = 1'b1; vend_chg = 2'd2;
      tick();                                  // t+10
      vend_vld = 1'b0; vend_chg = 2'd0;
      chk("bb2_done", done, 1);
      chk("bb2_chg", done_chg, 2);
      tick();

      // reset in the gap after the first coin
      pulse_start(4'd4);
      chk("rs_c1", coin, 2);
      tick();                                  // gap cycle
      #2 rst_n = 1'b0;
      #1;
      chk("rs_coin", coin, 0);
      chk("rs_busy", busy, 0);
      begin
         int seen = 0;
         #5 rst_n = 1'b1;
         for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen++;
         end
         chk("rs_no_done", seen, 0);
      end
      pulse_start(4'd4);
      chk("rs2_c1", coin, 2);
      tick(); tick();
      chk("rs2_c2", coin, 2);
      vend_vld = 1'b1;
      tick();
      vend_vld = 1'b0;
      tick();
      chk("rs2_done", done, 1);
      chk("rs2_left", done_left, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
